clk_tick_gen: RTL and testbench

CLK_TICK_GEN -- requirements
Module: clk_tick_gen

---
 rtl/clk_tick_gen.sv | 169 ++++++++++++++++
 tb/tb_clk_tick_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_tick_gen.sv
`timescale 1ns/1ps
// clk_tick_gen
// Multi-channel programmable clock divider with a sequenced reset output.
//
// Each channel produces a one-cycle tick at every half-period boundary and a
// 50% duty square wave that toggles on each tick. The half-period is
// (div + 1) clk cycles. Configuration changes to a running channel are parked
// in a single pending slot and applied on the channel's wrap edge, so a
// half-period is never shortened and the wave never glitches.
//
// Ports
//   clk        : block clock, all flops on the rising edge
//   rst_n      : asynchronous active-low reset
//   cfg_valid  : configuration request
//   cfg_ready  : request accepted this cycle when high together with cfg_valid
//   cfg_ch     : target channel index (indices >= N_CH are accepted and ignored)
//   cfg_div    : half-period minus one, in clk cycles
//   cfg_en     : channel run enable
//   tick       : per-channel one-cycle pulse at each half-period boundary
//   wave       : per-channel divided square wave
//   rst_out_n  : sequenced active-low reset for downstream logic
module clk_tick_gen #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 16
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     cfg_valid,
  output logic                                     cfg_ready,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                         cfg_div,
  input  logic                                     cfg_en,
  output logic [N_CH-1:0]                          tick,
  output logic [N_CH-1:0]                          wave,
  output logic                                     rst_out_n
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  // One extra count value so the sequencer can saturate at RST_CYCLES.
  localparam int SEQ_W = $clog2(RST_CYCLES + 1);

  // ---------------------------------------------------------------------------
  // Reset synchroniser and release sequencer
  // ---------------------------------------------------------------------------
  logic             sync1_r;
  logic             sync2_r;
  logic [SEQ_W-1:0] seq_cnt_r;
  logic             rst_out_n_r;

  // Two-flop synchroniser: asserts asynchronously, releases on clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= 1'b1;
      sync2_r <= sync1_r;
    end
  end

  // Release counter: rst_out_n rises on the RST_CYCLES-th edge with the
  // synchronised reset high, then the counter saturates until the next rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_cnt_r   <= '0;
      rst_out_n_r <= 1'b0;
    end else if (sync2_r && !rst_out_n_r) begin
      seq_cnt_r <= seq_cnt_r + SEQ_W'(1);
      if (seq_cnt_r == SEQ_W'(RST_CYCLES - 1)) begin
        rst_out_n_r <= 1'b1;
      end else begin
        rst_out_n_r <= 1'b0;
      end
    end else begin
      seq_cnt_r   <= seq_cnt_r;
      rst_out_n_r <= rst_out_n_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Divider channels
  // ---------------------------------------------------------------------------
  logic [N_CH-1:0]  en_r;
  logic [N_CH-1:0]  wave_r;
  logic [N_CH-1:0]  pend_r;
  logic [N_CH-1:0]  pend_en_r;
  logic [CNT_W-1:0] div_r      [N_CH];
  logic [CNT_W-1:0] cnt_r      [N_CH];
  logic [CNT_W-1:0] pend_div_r [N_CH];

  logic [N_CH-1:0]  tick_s;
  logic [N_CH-1:0]  hit_s;
  logic             cfg_ready_s;

  // Tick decode and configuration handshake. An out-of-range channel index
  // matches no channel, so it leaves cfg_ready high and is silently dropped.
  always_comb begin
    tick_s      = '0;
    hit_s       = '0;
    cfg_ready_s = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      tick_s[i] = en_r[i] && (cnt_r[i] == div_r[i]);
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready_s = ~pend_r[i];
        hit_s[i]    = cfg_valid && ~pend_r[i];
      end else begin
        hit_s[i]    = 1'b0;
      end
    end
  end

  // Channel state. A disabled channel loads new settings directly; a running
  // channel parks them in the pending slot until its wrap edge. The counter
  // only advances while below div and wraps to 0 at div, so it can never run
  // past div or roll over the CNT_W range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_r      <= '0;
      wave_r    <= '0;
      pend_r    <= '0;
      pend_en_r <= '0;
      for (int i = 0; i < N_CH; i++) begin
        div_r[i]      <= '0;
        cnt_r[i]      <= '0;
        pend_div_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!en_r[i]) begin
          cnt_r[i]  <= '0;
          wave_r[i] <= 1'b0;
          if (hit_s[i]) begin
            en_r[i]  <= cfg_en;
            div_r[i] <= cfg_div;
          end
        end else begin
          if (tick_s[i]) begin
            cnt_r[i] <= '0;
            if (pend_r[i]) begin
              div_r[i]  <= pend_div_r[i];
              en_r[i]   <= pend_en_r[i];
              pend_r[i] <= 1'b0;
              // A pending disable parks the wave low rather than toggling.
              wave_r[i] <= pend_en_r[i] ? ~wave_r[i] : 1'b0;
            end else begin
              wave_r[i] <= ~wave_r[i];
            end
          end else begin
            cnt_r[i] <= cnt_r[i] + CNT_W'(1);
          end
          // hit_s implies the slot was free before this edge, so this never
          // collides with the clear above.
          if (hit_s[i]) begin
            pend_r[i]     <= 1'b1;
            pend_div_r[i] <= cfg_div;
            pend_en_r[i]  <= cfg_en;
          end
        end
      end
    end
  end

  assign tick      = tick_s;
  assign wave      = wave_r;
  assign cfg_ready = cfg_ready_s;
  assign rst_out_n = rst_out_n_r;

endmodule

// File: tb/tb_clk_tick_gen.sv
`timescale 1ns/1ps
// Testbench for clk_tick_gen: randomized configuration traffic checked every
// cycle against a behavioural model, plus directed scenarios for periods,
// pending updates, stalls, disable-at-wrap and reset sequencing.
module tb_clk_tick_gen;

  localparam int N_CH       = 3;   // leaves cfg_ch == 3 as an out-of-range index
  localparam int CNT_W      = 16;
  localparam int RST_CYCLES = 16;
  localparam int CH_W       = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic             cfg_en = 1'b0;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  wave;
  logic             rst_out_n;

  clk_tick_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en),
    .tick(tick), .wave(wave), .rst_out_n(rst_out_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: each running channel counts down the cycles left in
  // its current half-period; a tick is due when none remain.
  bit m_en   [N_CH];
  int m_div  [N_CH];
  int m_left [N_CH];
  bit m_wave [N_CH];
  bit m_pend [N_CH];
  int m_pdiv [N_CH];
  bit m_pen  [N_CH];
  int rel_edges = 0;

  // Last sampled DUT values, for directed checks.
  logic [N_CH-1:0] last_tick;
  logic [N_CH-1:0] last_wave;
  logic            last_ready;
  logic            last_rst;
  int              tick_cnt [N_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N_CH; i++) begin
      m_en[i] = 1'b0; m_div[i] = 0; m_left[i] = 0; m_wave[i] = 1'b0;
      m_pend[i] = 1'b0; m_pdiv[i] = 0; m_pen[i] = 1'b0;
    end
    rel_edges = 0;
  endtask

  task automatic model_edge(input bit v, input int c, input int d, input bit e);
    bit acc;
    if (!rst_n) return;
    if (rel_edges < 1000) rel_edges++;
    acc = v && (c < N_CH) && !m_pend[c < N_CH ? c : 0];
    for (int i = 0; i < N_CH; i++) begin
      if (!m_en[i]) begin
        if (acc && c == i) begin
          m_en[i] = e; m_div[i] = d; m_left[i] = d; m_wave[i] = 1'b0;
        end
      end else begin
        if (m_left[i] == 0) begin
          m_wave[i] = !m_wave[i];
          if (m_pend[i]) begin
            m_div[i] = m_pdiv[i]; m_en[i] = m_pen[i]; m_pend[i] = 1'b0;
            if (!m_pen[i]) m_wave[i] = 1'b0;
          end
          m_left[i] = m_div[i];
        end else begin
          m_left[i]--;
        end
        if (acc && c == i) begin
          m_pend[i] = 1'b1; m_pdiv[i] = d; m_pen[i] = e;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    logic [N_CH-1:0] exp_tick;
    logic [N_CH-1:0] exp_wave;
    logic            exp_ready;
    logic            exp_rst;
    for (int i = 0; i < N_CH; i++) begin
      exp_tick[i] = m_en[i] && (m_left[i] == 0);
      exp_wave[i] = m_wave[i];
    end
    exp_ready = (int'(cfg_ch) >= N_CH) ? 1'b1 : !m_pend[cfg_ch];
    exp_rst   = rst_n && (rel_edges >= RST_CYCLES + 2);
    check("tick", 32'(tick), 32'(exp_tick));
    check("wave", 32'(wave), 32'(exp_wave));
    check("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
    check("rst_out_n", 32'(rst_out_n), 32'(exp_rst));
    last_tick = tick; last_wave = wave; last_ready = cfg_ready; last_rst = rst_out_n;
    for (int i = 0; i < N_CH; i++) if (tick[i] === 1'b1) tick_cnt[i]++;
  endtask

  // One clock cycle: drive on the falling edge, sample 1 ns later, then let
  // the model take the rising edge together with the DUT.
  task automatic step(input bit v, input int c, input int d, input bit e);
    @(negedge clk);
    cfg_valid = v; cfg_ch = CH_W'(c); cfg_div = CNT_W'(d); cfg_en = e;
    #1;
    compare_outputs();
    @(posedge clk);
    model_edge(v, c, d, e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1'b0);
  endtask

  task automatic clear_ticks();
    for (int i = 0; i < N_CH; i++) tick_cnt[i] = 0;
  endtask

  // Mid-cycle asynchronous reset pulse, then check the release sequence.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    model_clear();
    #1;
    check({tag, "_tick_clr"}, 32'(tick), 32'd0);
    check({tag, "_wave_clr"}, 32'(wave), 32'd0);
    check({tag, "_rstout_low"}, 32'(rst_out_n), 32'd0);
    check({tag, "_ready_hi"}, 32'(cfg_ready), 32'd1);
    idle(3);
    #2;
    rst_n = 1'b1;
    rel_edges = 0;
    idle(18);
    check({tag, "_rstout_17"}, 32'(last_rst), 32'd0);
    idle(1);
    check({tag, "_rstout_18"}, 32'(last_rst), 32'd1);
  endtask

  initial begin
    model_clear();
    clear_ticks();

    // Power-on reset and release sequence.
    idle(3);
    check("init_ready", 32'(last_ready), 32'd1);
    check("init_tick", 32'(last_tick), 32'd0);
    #2;
    rst_n = 1'b1;
    rel_edges = 0;
    idle(18);
    check("por_rstout_17", 32'(last_rst), 32'd0);
    idle(1);
    check("por_rstout_18", 32'(last_rst), 32'd1);
    idle(2);

    // ch0 at clk/2, ch1 half-period 5.
    step(1'b1, 0, 0, 1'b1);
    step(1'b1, 1, 4, 1'b1);
    clear_ticks();
    idle(40);
    check("ch0_ticks_40", 32'(tick_cnt[0]), 32'd40);
    check("ch1_ticks_40", 32'(tick_cnt[1]), 32'd8);

    // Pending update on ch1 requested at cnt == 2.
    for (int k = 0; k < 10 && m_left[1] != 2; k++) idle(1);
    step(1'b1, 1, 1, 1'b1);
    step(1'b1, 1, 3, 1'b1);
    check("ch1_stall", 32'(last_ready), 32'd0);
    step(1'b1, 2, 2, 1'b1);
    check("ch2_accept", 32'(last_ready), 32'd1);
    step(1'b0, 1, 0, 1'b0);
    check("ch1_ready_again", 32'(last_ready), 32'd1);
    clear_ticks();
    idle(20);
    check("ch1_new_ticks", 32'(tick_cnt[1]), 32'd10);

    // Disable ch0 through the pending slot.
    step(1'b1, 0, 2, 1'b0);
    idle(1);
    clear_ticks();
    idle(10);
    check("ch0_off_ticks", 32'(tick_cnt[0]), 32'd0);
    check("ch0_off_wave", 32'(last_wave[0]), 32'd0);

    // Out-of-range channel index is accepted and ignored.
    step(1'b1, 3, 7, 1'b1);
    check("oor_ready", 32'(last_ready), 32'd1);

    // Reset while ch2 holds a pending update.
    for (int k = 0; k < 10 && (m_left[2] == 0 || m_pend[2]); k++) idle(1);
    step(1'b1, 2, 5, 1'b1);
    step(1'b0, 2, 0, 1'b0);
    check("ch2_pending", 32'(last_ready), 32'd0);
    do_reset("rst_pend");

    // Randomized traffic.
    for (int k = 0; k < 2000; k++) begin
      bit v;
      bit e;
      int c;
      int d;
      v = ($urandom_range(0, 2) == 0);
      c = $urandom_range(0, 3);
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 5);
      e = ($urandom_range(0, 4) != 0);
      step(v, c, d, e);
      if (k == 1000) do_reset("rst_rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
